// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity modes and default bit timing
// used by both the TX and RX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned DEFAULT_OVERSAMPLE = 16;
    localparam int unsigned DEFAULT_SB_TICK    = 16;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops bytes from a show-ahead FIFO and shifts them out as
// start, LSB-first data, optional parity and stop, timed by an oversampling tick.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int unsigned SB_TICK    = DEFAULT_SB_TICK,
    parameter int unsigned PARITY     = PAR_NONE
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_tick,
    input  logic                 i_fifo_empty,
    input  logic [DATA_BITS-1:0] i_fifo_data,
    output logic                 o_fifo_read,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned TickMax = max_u(OVERSAMPLE, SB_TICK);
    localparam int unsigned TickW   = (TickMax > 1) ? $clog2(TickMax) : 1;
    localparam int unsigned BitW    = $clog2(DATA_BITS + 1);

    localparam logic [TickW-1:0] OsLast  = TickW'(OVERSAMPLE - 1);
    localparam logic [TickW-1:0] SbLast  = TickW'(SB_TICK - 1);
    localparam logic [BitW-1:0]  BitLast = BitW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 read_q, read_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tx_d       = tx_q;
        read_d     = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!i_fifo_empty) begin
                    shift_d    = i_fifo_data;
                    read_d     = 1'b1;
                    tx_d       = 1'b0;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    par_d      = 1'b0;
                    state_d    = StStart;
                end
            end

            StStart: begin
                if (i_tick) begin
                    if (tick_cnt_q == OsLast) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        tx_d       = shift_q[0];
                        state_d    = StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end

            StData: begin
                if (i_tick) begin
                    if (tick_cnt_q == OsLast) begin
                        tick_cnt_d = '0;
                        shift_d    = shift_q >> 1;
                        par_d      = par_q ^ shift_q[0];
                        bit_cnt_d  = bit_cnt_q + BitW'(1);
                        if (bit_cnt_q == BitLast) begin
                            if (PARITY != PAR_NONE) begin
                                // par_d now covers every data bit; odd mode inverts it
                                tx_d    = (PARITY == PAR_ODD) ? ~par_d : par_d;
                                state_d = StParity;
                            end else begin
                                tx_d    = 1'b1;
                                state_d = StStop;
                            end
                        end else begin
                            tx_d = shift_d[0];
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end

            StParity: begin
                if (i_tick) begin
                    if (tick_cnt_q == OsLast) begin
                        tick_cnt_d = '0;
                        tx_d       = 1'b1;
                        state_d    = StStop;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end

            StStop: begin
                tx_d = 1'b1;
                if (i_tick) begin
                    if (tick_cnt_q == SbLast) begin
                        tick_cnt_d = '0;
                        done_d     = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            read_q     <= read_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_tx        = tx_q;
    assign o_fifo_read = read_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule
